// File: rtl/parity_tx_pkg.sv
// parity_tx_pkg: shared types and constants for the parity serial transmitter.
//   DATA_W     - payload width in bits
//   FRAME_BITS - bits per serial frame (start + data + parity + stop)
//   tx_state_t - transmitter FSM states
package parity_tx_pkg;
    localparam int DATA_W     = 8;
    localparam int FRAME_BITS = 11;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
endpackage

// File: rtl/parity_calc.sv
// parity_calc: combinational parity of one byte with odd/even select.
//   data_i [DATA_W-1:0] - byte whose parity is computed
//   odd_i               - 0 = even parity (plain XOR), 1 = odd parity (inverted XOR)
//   par_o               - resulting parity bit
module parity_calc
    import parity_tx_pkg::*;
(
    input  logic [DATA_W-1:0] data_i,
    input  logic              odd_i,
    output logic              par_o
);
    assign par_o = ^data_i ^ odd_i;
endmodule

// File: rtl/parity_serial_tx.sv
// parity_serial_tx: accepts a byte on valid/ready and sends an LSB-first 11-bit frame (start, 8 data, parity, stop).
//   clk        - rising-edge clock
//   rst_n      - asynchronous active-low reset
//   tx_data    - byte to transmit, sampled on handshake only
//   tx_valid   - producer has a byte on tx_data
//   tx_ready   - block can accept a byte this cycle (IDLE only)
//   tx_serial  - serial line, idles high
//   tx_busy    - a frame is in flight
//   frame_done - one-cycle pulse on the last clock of the stop bit
module parity_serial_tx
    import parity_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter bit ODD_PARITY   = 1'b0
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_serial,
    output logic              tx_busy,
    output logic              frame_done
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    tx_state_t         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_q, par_d;
    logic              par_w;
    logic              bit_end;

    parity_calc u_parity_calc (
        .data_i (tx_data),
        .odd_i  (ODD_PARITY),
        .par_o  (par_w)
    );

    assign bit_end = cnt_q == LAST;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        if (state_q == IDLE) begin
            cnt_d = '0;
            bit_d = '0;
            if (tx_valid) begin
                shift_d = tx_data;
                par_d   = par_w;
                state_d = START;
            end
        end else begin
            // Counter restarts on every bit boundary so each bit lasts exactly CLKS_PER_BIT cycles.
            cnt_d = bit_end ? '0 : cnt_q + CW'(1);
            if (bit_end) begin
                case (state_q)
                    START:   state_d = DATA;
                    DATA: begin
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) state_d = PARITY;
                    end
                    PARITY:  state_d = STOP;
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
        end
    end

    // Outputs decode straight from registers, so an async reset forces the idle line at once.
    assign tx_ready   = state_q == IDLE;
    assign tx_busy    = state_q != IDLE;
    assign frame_done = (state_q == STOP) && bit_end;
    assign tx_serial  = (state_q == START)  ? 1'b0       :
                        (state_q == DATA)   ? shift_q[0] :
                        (state_q == PARITY) ? par_q      : 1'b1;
endmodule

// File: tb/tb_parity_serial_tx.sv
// tb_parity_serial_tx: directed bench; instance 0 = 4 clk/bit even, 1 = 4 clk/bit odd, 2 = 2 clk/bit even.
module tb_parity_serial_tx;
    logic       clk = 1'b0;
    logic [2:0] rst_n;
    logic [7:0] tx_data [3];
    logic [2:0] tx_valid;
    logic [2:0] tx_ready;
    logic [2:0] tx_serial;
    logic [2:0] tx_busy;
    logic [2:0] frame_done;
    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        parity_serial_tx #(
            .CLKS_PER_BIT (g == 2 ? 2 : 4),
            .ODD_PARITY   (g == 1)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n[g]),
            .tx_data    (tx_data[g]),
            .tx_valid   (tx_valid[g]),
            .tx_ready   (tx_ready[g]),
            .tx_serial  (tx_serial[g]),
            .tx_busy    (tx_busy[g]),
            .frame_done (frame_done[g])
        );
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Sends byte d (expected parity p) and checks every cycle of the frame.
    // hold: keep tx_valid high and present late_d for the next frame; otherwise late_d overwrites tx_data mid-DATA.
    task automatic send(input int i, input logic [7:0] d, input logic p, input logic [7:0] late_d,
                        input bit hold, input string tag);
        int cpb;
        int n;
        int k;
        logic [10:0] fr;
        logic [63:0] done_v, rdy_v, busy_v;
        logic [3:0]  sv;
        cpb = (i == 2) ? 2 : 4;
        n = 11 * cpb;
        k = 0;
        fr = {1'b1, p, d, 1'b0};
        done_v = '0;
        rdy_v = '0;
        busy_v = '0;
        tx_data[i] = d;
        tx_valid[i] = 1'b1;
        chk({tag, "_ready_before"}, 64'(tx_ready[i]), 64'd1);
        @(negedge clk);
        if (hold) tx_data[i] = late_d;
        else tx_valid[i] = 1'b0;
        for (int b = 0; b < 11; b++) begin
            sv = '0;
            for (int c = 0; c < cpb; c++) begin
                sv[c] = tx_serial[i];
                done_v[k] = frame_done[i];
                rdy_v[k] = tx_ready[i];
                busy_v[k] = tx_busy[i];
                if (!hold && b == 3 && c == 0) tx_data[i] = late_d;
                k++;
                if (k < n) @(negedge clk);
            end
            chk($sformatf("%s_bit%0d", tag, b), 64'(sv), fr[b] ? (64'd1 << cpb) - 64'd1 : 64'd0);
        end
        chk({tag, "_frame_done"}, done_v, 64'd1 << (n - 1));
        chk({tag, "_ready_in_frame"}, rdy_v, 64'd0);
        chk({tag, "_busy_in_frame"}, busy_v, (64'd1 << n) - 64'd1);
    endtask

    task automatic idle(input int i, input string tag);
        @(negedge clk);
        chk({tag, "_idle_ready"}, 64'(tx_ready[i]), 64'd1);
        chk({tag, "_idle_done"}, 64'(frame_done[i]), 64'd0);
        chk({tag, "_idle_serial"}, 64'(tx_serial[i]), 64'd1);
    endtask

    initial begin
        logic bad_done, bad_ready;
        rst_n = '0;
        tx_valid = '0;
        for (int i = 0; i < 3; i++) tx_data[i] = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_serial", 64'(tx_serial), 64'h7);
        chk("rst_ready", 64'(tx_ready), 64'h7);
        chk("rst_busy", 64'(tx_busy), 64'h0);
        chk("rst_done", 64'(frame_done), 64'h0);
        rst_n = '1;
        @(negedge clk);

        send(0, 8'hA5, 1'b0, 8'hA5, 1'b0, "a5_even");
        idle(0, "a5_even");
        send(0, 8'h07, 1'b1, 8'h07, 1'b0, "07_even");
        idle(0, "07_even");
        send(1, 8'h07, 1'b0, 8'h07, 1'b0, "07_odd");
        idle(1, "07_odd");
        send(1, 8'h00, 1'b1, 8'h00, 1'b0, "00_odd");
        idle(1, "00_odd");

        send(0, 8'h3C, 1'b0, 8'hC3, 1'b1, "b2b_3c");
        idle(0, "b2b_3c");
        send(0, 8'hC3, 1'b0, 8'hC3, 1'b0, "b2b_c3");
        idle(0, "b2b_c3");

        send(0, 8'h55, 1'b0, 8'hFF, 1'b0, "late_change");
        idle(0, "late_change");

        send(2, 8'hFF, 1'b0, 8'hFF, 1'b0, "cpb2_ff");
        idle(2, "cpb2_ff");

        tx_data[0] = 8'h0F;
        tx_valid[0] = 1'b1;
        @(negedge clk);
        tx_valid[0] = 1'b0;
        repeat (20) @(negedge clk);
        chk("mid_bit4_serial", 64'(tx_serial[0]), 64'd0);
        chk("mid_bit4_busy", 64'(tx_busy[0]), 64'd1);
        #2 rst_n[0] = 1'b0;
        #1;
        chk("async_rst_serial", 64'(tx_serial[0]), 64'd1);
        chk("async_rst_busy", 64'(tx_busy[0]), 64'd0);
        chk("async_rst_ready", 64'(tx_ready[0]), 64'd1);
        @(negedge clk);
        rst_n[0] = 1'b1;
        bad_done = 1'b0;
        bad_ready = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            bad_done |= frame_done[0];
            bad_ready |= ~tx_ready[0];
        end
        chk("post_rst_no_done", 64'(bad_done), 64'd0);
        chk("post_rst_ready", 64'(bad_ready), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/parity_serial_tx.md
Name: parity_serial_tx

Overview:
Downstream consumer of the 8-bit parity stage. It accepts a byte over a valid/ready handshake and computes that byte's parity bit. It then serialises an 11-bit frame, LSB-first: start, 8 data, parity, stop. The block sits between the byte-producing datapath and the external serial line.

Parameters:
CLKS_PER_BIT, 16, clock cycles per serial bit; legal range >= 2
ODD_PARITY, 0, 0 = even parity (parity bit = XOR of data bits); 1 = odd parity (inverted XOR)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
tx_data  input  8  byte to transmit; sampled only on handshake
tx_valid  input  1  producer has a byte on tx_data
tx_ready  output  1  block can accept a byte this cycle
tx_serial  output  1  serial line; idles high
tx_busy  output  1  high while a frame is in flight (any state except IDLE)
frame_done  output  1  one-cycle pulse on the last clock of the stop bit

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values (applied immediately on rst_n low):
  - tx_serial=1, tx_ready=1, tx_busy=0, frame_done=0.
  - State is IDLE; bit counter and clock counter are 0.
- Reset mid-frame: tx_serial goes to 1 at once and the frame is dropped. After release, the block is in IDLE.
- FSM states: IDLE, START, DATA, PARITY, STOP. All outputs are registered or decoded directly from the state register.
- IDLE:
  - tx_ready=1, tx_serial=1.
  - Handshake occurs when tx_valid && tx_ready at a rising edge.
  - On handshake: latch shift_reg <= tx_data and par <= ^tx_data ^ ODD_PARITY, then go to START.
- START: tx_serial=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - tx_serial=shift_reg[0]; each bit lasts CLKS_PER_BIT cycles, then shift right.
  - 3-bit counter; after bit index 7, go to PARITY.
- PARITY: tx_serial=par for CLKS_PER_BIT cycles, then go to STOP.
- STOP:
  - tx_serial=1 for CLKS_PER_BIT cycles.
  - frame_done=1 on the final cycle, then go to IDLE.
- Timing:
  - First start-bit cycle is the cycle after the handshake.
  - Frame length is exactly 11*CLKS_PER_BIT cycles.
  - IDLE lasts at least 1 cycle between frames, so back-to-back period is 11*CLKS_PER_BIT+1 cycles.
- tx_ready is 0 in every non-IDLE state. tx_valid and tx_data are ignored then; no byte is accepted or lost silently, and the producer must hold the byte until accepted.
- Changes on tx_data after the handshake have no effect on the frame in flight.
- Clock counter width is $clog2(CLKS_PER_BIT). It resets to 0 on every bit boundary and never wraps mid-bit.

Decomposition:
- Package parity_tx_pkg holds:
  - state enum tx_state_t {IDLE, START, DATA, PARITY, STOP}
  - DATA_W=8
  - FRAME_BITS=11
- One sub-module, parity_calc: purely combinational 8-bit XOR reduction with an odd/even select input. It is instantiated once and feeds the par latch.

Test Plan:
- CLKS_PER_BIT=4, even; send 0xA5 -> tx_serial per 4-cycle bit is 0,1,0,1,0,0,1,0,1,0,1 (parity 0); frame_done pulses at cycle 44 after the handshake.
- Even mode, send 0x07 -> parity bit 1; odd mode, send 0x07 -> parity bit 0; odd mode, send 0x00 -> parity bit 1.
- tx_valid held high with 0x3C then 0xC3 -> two frames, second handshake exactly 1 cycle after frame_done; tx_ready low throughout each frame.
- Change tx_data from 0x55 to 0xFF during the DATA state -> serialised bits still 0x55 LSB-first with even parity 0.
- Assert rst_n low during bit 4 of DATA -> tx_serial=1 and tx_busy=0 in the same cycle without waiting for a clock; after release, tx_ready=1 and no frame_done pulse.
- CLKS_PER_BIT=2 build, send 0xFF -> 22-cycle frame, parity 0 (even), stop bit high for 2 cycles.
